// File: rtl/burst_ram_responder.sv
// burst_ram_responder: BSRAM-backed stand-in for the PSRAM burst command interface.
// Define BURST_RAM_CALIB_DELAY_EN to model a CALIB_CYCLES-long calibration after reset.
module burst_ram_responder #(
    parameter int DEPTH_BITWIDTH = 12,
    parameter int BURST_BEATS    = 4,
    parameter int READ_LATENCY   = 6,
    parameter int CMD_INTERVAL   = 12,
    parameter int CALIB_CYCLES   = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        br_cmd,
    input  logic        br_cmd_en,
    input  logic [20:0] br_addr,
    input  logic [63:0] br_wr_data,
    input  logic [7:0]  br_data_mask,
    output logic [63:0] br_rd_data,
    output logic        br_rd_data_valid,
    output logic        init_calib,
    output logic        protocol_error
);
    localparam int CW = $clog2((CALIB_CYCLES > CMD_INTERVAL ? CALIB_CYCLES : CMD_INTERVAL) + 1);
    localparam int DB = DEPTH_BITWIDTH;

    typedef enum logic [2:0] {CALIB, IDLE, WRITE, READ_WAIT, READ_DATA, COOLDOWN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DB-1:0]   addr_q, addr_d;
    logic            valid_q, valid_d;
    logic            init_q, init_d;
    logic            perr_q, perr_d;
    logic            wr_en;
    logic [DB-1:0]   wr_addr, rd_addr;
    logic [63:0]     rd_q;
    logic [63:0]     mem [0:(1<<DB)-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        addr_d  = addr_q;
        valid_d = 1'b0;
        init_d  = init_q;
        perr_d  = perr_q | (br_cmd_en && state_q != IDLE);
        wr_en   = 1'b0;
        wr_addr = addr_q + DB'(cnt_q);
        // Read address runs one cycle ahead of the registered BSRAM output.
        rd_addr = addr_q + DB'(cnt_q - CW'(READ_LATENCY));
        case (state_q)
            CALIB: begin
`ifdef BURST_RAM_CALIB_DELAY_EN
                if (cnt_q == CW'(CALIB_CYCLES - 1)) begin
                    state_d = IDLE;
                    init_d  = 1'b1;
                    cnt_d   = '0;
                end
`else
                state_d = IDLE;
                init_d  = 1'b1;
                cnt_d   = '0;
`endif
            end
            IDLE: begin
                cnt_d = cnt_q;
                if (br_cmd_en && init_q) begin
                    addr_d  = br_addr[DB-1:0];
                    cnt_d   = CW'(1);
                    wr_en   = br_cmd;
                    wr_addr = br_addr[DB-1:0];
                    state_d = br_cmd ? (BURST_BEATS > 1 ? WRITE : COOLDOWN) : READ_WAIT;
                end
            end
            WRITE: begin
                wr_en = 1'b1;
                if (cnt_q == CW'(BURST_BEATS - 1))
                    state_d = COOLDOWN;
            end
            READ_WAIT: begin
                if (cnt_q == CW'(READ_LATENCY)) begin
                    valid_d = 1'b1;
                    state_d = READ_DATA;
                end
            end
            READ_DATA: begin
                if (cnt_q == CW'(READ_LATENCY + BURST_BEATS))
                    state_d = COOLDOWN;
                else
                    valid_d = 1'b1;
            end
            COOLDOWN: begin
                if (cnt_q >= CW'(CMD_INTERVAL - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = CALIB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CALIB;
            cnt_q   <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            init_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            init_q  <= init_d;
            perr_q  <= perr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            for (int b = 0; b < 8; b++)
                if (!br_data_mask[b])
                    mem[wr_addr][8*b +: 8] <= br_wr_data[8*b +: 8];
        rd_q <= mem[rd_addr];
    end

    assign br_rd_data       = valid_q ? rd_q : '0;
    assign br_rd_data_valid = valid_q;
    assign init_calib       = init_q;
    assign protocol_error   = perr_q;
endmodule

// File: tb/tb_burst_ram_responder.sv
// tb_burst_ram_responder: directed vector table plus hand-written reset/calibration/interval sequences.
module tb_burst_ram_responder;
    localparam int RL = 6;
    localparam int BB = 4;
`ifdef BURST_RAM_CALIB_DELAY_EN
    localparam int CAL = 64;
`else
    localparam int CAL = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        br_cmd = 1'b0;
    logic        br_cmd_en = 1'b0;
    logic [20:0] br_addr = '0;
    logic [63:0] br_wr_data = '0;
    logic [7:0]  br_data_mask = '0;
    logic [63:0] br_rd_data;
    logic        br_rd_data_valid;
    logic        init_calib;
    logic        protocol_error;

    burst_ram_responder dut (
        .clk(clk), .rst_n(rst_n), .br_cmd(br_cmd), .br_cmd_en(br_cmd_en),
        .br_addr(br_addr), .br_wr_data(br_wr_data), .br_data_mask(br_data_mask),
        .br_rd_data(br_rd_data), .br_rd_data_valid(br_rd_data_valid),
        .init_calib(init_calib), .protocol_error(protocol_error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             wr;
        logic [20:0]      addr;
        logic [3:0][63:0] d;
        logic [3:0][7:0]  m;
    } vec_t;

    int nvec = 0;
    int nfail = 0;

    localparam logic [63:0] VA = 64'hAAAA_0000_AAAA_0001;
    localparam logic [63:0] VB = 64'hBBBB_0000_BBBB_0002;
    localparam logic [63:0] VC = 64'hCCCC_0000_CCCC_0003;
    localparam logic [63:0] VD = 64'hDDDD_0000_DDDD_0004;
    localparam logic [63:0] E0 = 64'h0123_4567_89AB_CDE0;
    localparam logic [63:0] E1 = 64'h0123_4567_89AB_CDE1;
    localparam logic [63:0] E2 = 64'h0123_4567_89AB_CDE2;
    localparam logic [63:0] E3 = 64'h0123_4567_89AB_CDE3;
    localparam logic [63:0] F0 = 64'hF00D_0000_0000_0F00;
    localparam logic [63:0] F1 = 64'hF00D_1111_0000_0F01;
    localparam logic [63:0] F2 = 64'hF00D_2222_0000_0F02;
    localparam logic [63:0] F3 = 64'hF00D_3333_0000_0F03;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [20:0] a,
                                input logic [63:0] d0, d1, d2, d3,
                                input logic [7:0] m0, input logic [7:0] mr);
        vec_t v;
        v.wr = wr;
        v.addr = a;
        v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
        v.m[0] = m0; v.m[1] = mr; v.m[2] = mr; v.m[3] = mr;
        return v;
    endfunction

    task automatic wait_init(output int n);
        n = 0;
        while (!init_calib && n < 300) begin
            tick();
            n++;
        end
    endtask

    // Issues a write burst and idles so the next command lands exactly 12 edges later.
    task automatic do_write(input vec_t v);
        br_cmd = 1'b1;
        br_addr = v.addr;
        br_wr_data = v.d[0];
        br_data_mask = v.m[0];
        br_cmd_en = 1'b1;
        tick();
        br_cmd_en = 1'b0;
        for (int k = 1; k < BB; k++) begin
            br_wr_data = v.d[k];
            br_data_mask = v.m[k];
            tick();
        end
        repeat (8) tick();
    endtask

    // Issues a read and observes 11 cycles; inj>0 drives an illegal write strobe on that cycle.
    task automatic check_read(input string name, input logic [20:0] a,
                              input logic [3:0][63:0] exp, input int inj);
        logic [3:0][63:0] got;
        logic [63:0] tail;
        int first;
        int nv;
        got = {4{64'hDEAD_BEEF_DEAD_BEEF}};
        tail = '0;
        first = -1;
        nv = 0;
        br_cmd = 1'b0;
        br_addr = a;
        br_cmd_en = 1'b1;
        tick();
        br_cmd_en = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            if (i == inj) begin
                br_cmd = 1'b1;
                br_addr = 21'h020;
                br_wr_data = '0;
                br_data_mask = '0;
                br_cmd_en = 1'b1;
            end
            tick();
            br_cmd_en = 1'b0;
            if (br_rd_data_valid) begin
                nv++;
                if (first < 0) first = i;
                if (i >= RL && i < RL + BB) got[i-RL] = br_rd_data;
            end
            if (i == RL + BB) tail = br_rd_data;
        end
        chk($sformatf("%s_latency", name), 64'(first), 64'(RL));
        chk($sformatf("%s_beats", name), 64'(nv), 64'(BB));
        for (int k = 0; k < BB; k++)
            chk($sformatf("%s_beat%0d", name, k), got[k], exp[k]);
        chk($sformatf("%s_data_after_burst", name), tail, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vec_t tv[14];
        int n;
        int nv;
        tv[0]  = mk(1, 21'h010, {4{16'h1111}}, {4{16'h2222}}, {4{16'h3333}}, {4{16'h4444}}, 8'h00, 8'h00);
        tv[1]  = mk(0, 21'h010, {4{16'h1111}}, {4{16'h2222}}, {4{16'h3333}}, {4{16'h4444}}, 8'h00, 8'h00);
        tv[2]  = mk(1, 21'h020, ONES, ONES, ONES, ONES, 8'h00, 8'h00);
        tv[3]  = mk(1, 21'h020, 64'd0, 64'd0, 64'd0, 64'd0, 8'hF0, 8'hFF);
        tv[4]  = mk(0, 21'h020, 64'hFFFF_FFFF_0000_0000, ONES, ONES, ONES, 8'h00, 8'h00);
        tv[5]  = mk(1, 21'h000, E0, E1, E2, E3, 8'h00, 8'h00);
        tv[6]  = mk(1, 21'hFFE, VA, VB, VC, VD, 8'h00, 8'h00);
        tv[7]  = mk(0, 21'hFFE, VA, VB, VC, VD, 8'h00, 8'h00);
        tv[8]  = mk(0, 21'hFFF, VB, VC, VD, E2, 8'h00, 8'h00);
        tv[9]  = mk(0, 21'h000, VC, VD, E2, E3, 8'h00, 8'h00);
        tv[10] = mk(0, 21'h100FFE, VA, VB, VC, VD, 8'h00, 8'h00);
        tv[11] = mk(1, 21'h101008, F0, F1, F2, F3, 8'h00, 8'h00);
        tv[12] = mk(0, 21'h000008, F0, F1, F2, F3, 8'h00, 8'h00);
        tv[13] = mk(0, 21'h1FF008, F0, F1, F2, F3, 8'h00, 8'h00);

        #2;
        chk("reset_valid", 64'(br_rd_data_valid), 64'd0);
        chk("reset_data", br_rd_data, 64'd0);
        chk("reset_init", 64'(init_calib), 64'd0);
        chk("reset_perr", 64'(protocol_error), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        wait_init(n);
        chk("calib_cycles", 64'(n), 64'(CAL));
        chk("calib_perr", 64'(protocol_error), 64'd0);

        // Strobe during calibration: flagged and ignored.
        rst_n = 1'b0;
        #2;
        br_cmd = 1'b0;
        br_addr = 21'h010;
        br_cmd_en = 1'b1;
        rst_n = 1'b1;
        tick();
        br_cmd_en = 1'b0;
        chk("calib_cmd_perr", 64'(protocol_error), 64'd1);
        nv = 0;
        for (int i = 0; i < CAL + 14; i++) begin
            tick();
            if (br_rd_data_valid) nv++;
        end
        chk("calib_cmd_no_data", 64'(nv), 64'd0);
        chk("calib_cmd_perr_sticky", 64'(protocol_error), 64'd1);

        rst_n = 1'b0;
        #2;
        chk("rerst_perr_clear", 64'(protocol_error), 64'd0);
        rst_n = 1'b1;
        wait_init(n);
        chk("rerst_calib_cycles", 64'(n), 64'(CAL));

        for (int i = 0; i < 14; i++) begin
            if (tv[i].wr) do_write(tv[i]);
            else check_read($sformatf("vec%0d", i), tv[i].addr, tv[i].d, -1);
        end
        chk("table_perr", 64'(protocol_error), 64'd0);

        // Write strobe 5 cycles into a read: read completes, write target untouched.
        check_read("interval_read", 21'h010, tv[1].d, 5);
        chk("interval_perr", 64'(protocol_error), 64'd1);
        check_read("interval_target", 21'h020, tv[4].d, -1);

        // Asynchronous reset on the second valid beat.
        br_cmd = 1'b0;
        br_addr = 21'h010;
        br_cmd_en = 1'b1;
        tick();
        br_cmd_en = 1'b0;
        nv = 0;
        n = 0;
        while (nv < 2 && n < 20) begin
            tick();
            n++;
            if (br_rd_data_valid) nv++;
        end
        chk("midread_second_beat_cycle", 64'(n), 64'(RL + 1));
        rst_n = 1'b0;
        #1;
        chk("midread_valid_async", 64'(br_rd_data_valid), 64'd0);
        chk("midread_data_async", br_rd_data, 64'd0);
        chk("midread_init_async", 64'(init_calib), 64'd0);
        chk("midread_perr_cleared", 64'(protocol_error), 64'd0);
        #2;
        rst_n = 1'b1;
        wait_init(n);
        chk("midread_calib_cycles", 64'(n), 64'(CAL));
        check_read("retained", 21'h010, tv[1].d, -1);
        chk("final_perr", 64'(protocol_error), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
